vga_sync_receiver: RTL and testbench

//  Receive end of the VGA link: samples H_SYNC/V_SYNC/RGB from a VGA_Controller-style source.

---
 rtl/vga_sync_receiver.sv | 190 +++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Receive side of the VGA link: recovers raster coordinates from H/V sync, measures line and
// frame timing, locks onto the expected mode and re-emits the active-window pixels.
module vga_sync_receiver #(
  parameter int DATA_W       = 10,
  parameter int H_SYNC_CYC   = 96,
  parameter int H_SYNC_TOTAL = 800,
  parameter int X_START      = 144,
  parameter int H_SYNC_ACT   = 640,
  parameter int V_SYNC_CYC   = 2,
  parameter int V_SYNC_TOTAL = 525,
  parameter int Y_START      = 35,
  parameter int V_SYNC_ACT   = 480,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iPixel_En,
  input  logic              iVGA_H_SYNC,
  input  logic              iVGA_V_SYNC,
  input  logic [DATA_W-1:0] iVGA_R,
  input  logic [DATA_W-1:0] iVGA_G,
  input  logic [DATA_W-1:0] iVGA_B,
  output logic [9:0]        oCoord_X,
  output logic [9:0]        oCoord_Y,
  output logic [DATA_W-1:0] oVGA_R,
  output logic [DATA_W-1:0] oVGA_G,
  output logic [DATA_W-1:0] oVGA_B,
  output logic              oPixel_Valid,
  output logic              oFrame_Start,
  output logic              oLocked,
  output logic              oErr,
  output logic [10:0]       oH_Total,
  output logic [10:0]       oH_Sync_W,
  output logic [10:0]       oV_Total,
  output logic [10:0]       oV_Sync_W
);

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] H_TOT   = 11'(H_SYNC_TOTAL);
  localparam logic [10:0] H_SW    = 11'(H_SYNC_CYC);
  localparam logic [10:0] V_TOT   = 11'(V_SYNC_TOTAL);
  localparam logic [10:0] V_SW    = 11'(V_SYNC_CYC);
  localparam logic [10:0] X_LO    = 11'(X_START);
  localparam logic [10:0] X_HI    = 11'(X_START + H_SYNC_ACT);
  localparam logic [10:0] Y_LO    = 11'(Y_START);
  localparam logic [10:0] Y_HI    = 11'(Y_START + V_SYNC_ACT);
  localparam logic [2:0]  LOCK_L  = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  state_t      state;
  logic [2:0]  good_cnt;
  logic        h_prev, v_prev, pend_v, h_wait, v_wait, vw_good, line_err;
  logic [10:0] h_cnt, v_cnt;
  logic        h_fall, v_fall, fs_now, hw_meas, vw_meas, ln_bad, sync_lost, frame_good, in_win;
  logic [10:0] h_inc, v_inc, h_new, v_new;
  logic              vld_p1;
  logic [DATA_W-1:0] r_p1, g_p1, b_p1;
  logic [9:0]        x_p1, y_p1;

  // Sample stage: edge detection and the counts assigned to the current sample
  always_comb begin
    h_fall     = iPixel_En & h_prev & ~iVGA_H_SYNC;
    v_fall     = iPixel_En & v_prev & ~iVGA_V_SYNC;
    fs_now     = h_fall & (pend_v | v_fall);
    h_inc      = sat_inc(h_cnt);
    v_inc      = sat_inc(v_cnt);
    h_new      = h_fall ? 11'd0 : h_inc;
    v_new      = fs_now ? 11'd0 : (h_fall ? v_inc : v_cnt);
    hw_meas    = iPixel_En & h_wait & iVGA_H_SYNC;
    vw_meas    = h_fall & ~fs_now & v_wait & iVGA_V_SYNC;
    ln_bad     = (h_fall & (h_inc != H_TOT)) | (hw_meas & (h_new != H_SW));
    sync_lost  = iPixel_En & (((h_new == CNT_MAX) & (h_cnt != CNT_MAX)) |
                              ((v_new == CNT_MAX) & (v_cnt != CNT_MAX)));
    // the line closed by the frame-start fall still belongs to the frame being judged
    frame_good = ~line_err & ~ln_bad & (v_inc == V_TOT) & vw_good;
    in_win     = (h_new >= X_LO) & (h_new < X_HI) & (v_new >= Y_LO) & (v_new < Y_HI);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      h_prev <= 1'b0; v_prev <= 1'b0; pend_v <= 1'b0;
      h_wait <= 1'b0; v_wait <= 1'b0; vw_good <= 1'b0; line_err <= 1'b0;
      h_cnt <= '0; v_cnt <= '0;
      oH_Total <= '0; oH_Sync_W <= '0; oV_Total <= '0; oV_Sync_W <= '0;
      oFrame_Start <= 1'b0;
    end else begin
      oFrame_Start <= fs_now;
      if (iPixel_En) begin
        h_prev   <= iVGA_H_SYNC;
        v_prev   <= iVGA_V_SYNC;
        h_cnt    <= h_new;
        v_cnt    <= v_new;
        pend_v   <= (pend_v | v_fall) & ~fs_now;
        line_err <= fs_now ? 1'b0 : (line_err | ln_bad);
        if (h_fall) begin
          oH_Total <= h_inc;
          h_wait   <= 1'b1;
        end else if (hw_meas) begin
          oH_Sync_W <= h_new;
          h_wait    <= 1'b0;
        end
        if (fs_now) begin
          oV_Total <= v_inc;
          v_wait   <= 1'b1;
          vw_good  <= 1'b0;
        end else if (vw_meas) begin
          oV_Sync_W <= v_new;
          v_wait    <= 1'b0;
          vw_good   <= (v_new == V_SW);
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
      oLocked  <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      oErr <= 1'b0;
      if (sync_lost) begin
        state    <= SEARCH;
        good_cnt <= '0;
        oLocked  <= 1'b0;
        oErr     <= 1'b1;
      end else if (fs_now) begin
        unique case (state)
          SEARCH: begin
            state    <= VERIFY;
            good_cnt <= '0;
          end
          VERIFY: begin
            if (frame_good) begin
              good_cnt <= good_cnt + 3'd1;
              if (good_cnt + 3'd1 == LOCK_L) begin
                state   <= LOCKED;
                oLocked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
              oErr     <= 1'b1;
            end
          end
          LOCKED: begin
            if (!frame_good) begin
              state   <= SEARCH;
              oLocked <= 1'b0;
              oErr    <= 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Output stage p1: captured pixel, one Clock after its sample
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vld_p1 <= 1'b0;
      r_p1 <= '0; g_p1 <= '0; b_p1 <= '0;
      x_p1 <= '0; y_p1 <= '0;
    end else if (iPixel_En && in_win && state == LOCKED) begin
      vld_p1 <= 1'b1;
      r_p1   <= iVGA_R;
      g_p1   <= iVGA_G;
      b_p1   <= iVGA_B;
      x_p1   <= 10'(h_new - X_LO);
      y_p1   <= 10'(v_new - Y_LO);
    end else begin
      vld_p1 <= 1'b0;
      r_p1 <= '0; g_p1 <= '0; b_p1 <= '0;
    end
  end

  assign oPixel_Valid = vld_p1;
  assign oVGA_R       = r_p1;
  assign oVGA_G       = g_p1;
  assign oVGA_B       = b_p1;
  assign oCoord_X     = x_p1;
  assign oCoord_Y     = y_p1;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down raster: frame-level vector table plus a pixel scoreboard.
module tb_vga_sync_receiver;

  localparam int H_TOT  = 20;
  localparam int H_SYNC = 3;
  localparam int X_ST   = 5;
  localparam int H_ACT  = 10;
  localparam int V_TOT  = 12;
  localparam int V_SYNC = 2;
  localparam int Y_ST   = 3;
  localparam int V_ACT  = 6;
  localparam int FULL   = 100000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iPixel_En = 1'b0;
  logic       iVGA_H_SYNC = 1'b1;
  logic       iVGA_V_SYNC = 1'b1;
  logic [9:0] iVGA_R = '0, iVGA_G = '0, iVGA_B = '0;
  logic [9:0] oCoord_X, oCoord_Y, oVGA_R, oVGA_G, oVGA_B;
  logic       oPixel_Valid, oFrame_Start, oLocked, oErr;
  logic [10:0] oH_Total, oH_Sync_W, oV_Total, oV_Sync_W;

  vga_sync_receiver #(
    .DATA_W(10), .H_SYNC_CYC(H_SYNC), .H_SYNC_TOTAL(H_TOT), .X_START(X_ST), .H_SYNC_ACT(H_ACT),
    .V_SYNC_CYC(V_SYNC), .V_SYNC_TOTAL(V_TOT), .Y_START(Y_ST), .V_SYNC_ACT(V_ACT), .LOCK_FRAMES(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iPixel_En(iPixel_En),
    .iVGA_H_SYNC(iVGA_H_SYNC), .iVGA_V_SYNC(iVGA_V_SYNC),
    .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
    .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oPixel_Valid(oPixel_Valid), .oFrame_Start(oFrame_Start), .oLocked(oLocked), .oErr(oErr),
    .oH_Total(oH_Total), .oH_Sync_W(oH_Sync_W), .oV_Total(oV_Total), .oV_Sync_W(oV_Sync_W)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int nlines;     // lines in this frame
    int short_line; // line driven with H_TOT-1 pixels (-1: none)
    int wide_line;  // line driven with H sync one pixel too wide (-1: none)
    int max_pix;    // stop after this many pixels
    int early;      // V fall placed 5 pixels before this frame's first H fall
    int exp_lk;     // oLocked expected throughout the frame
    int exp_err;    // oErr pulses expected during the frame
    int exp_vtot;   // oV_Total expected (0: not checked)
    int exp_valid;  // oPixel_Valid strobes expected during the frame
  } vec_t;

  typedef struct packed {
    logic [9:0] x, y, r, g, b;
  } pix_t;

  pix_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   fs_tot = 0, err_tot = 0, vld_tot = 0;
  int   v_low_left = 0;
  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts pulses and pops the scoreboard on every captured pixel
  always @(posedge Clock) begin
    #1;
    if (!Reset) begin
      if (oFrame_Start) fs_tot++;
      if (oErr) err_tot++;
      if (oPixel_Valid) begin
        pix_t e;
        vld_tot++;
        chk("valid_latency_en", int'(iPixel_En), 1);
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("coord_x", int'(oCoord_X), int'(e.x));
          chk("coord_y", int'(oCoord_Y), int'(e.y));
          chk("red",     int'(oVGA_R),   int'(e.r));
          chk("green",   int'(oVGA_G),   int'(e.g));
          chk("blue",    int'(oVGA_B),   int'(e.b));
        end
      end
    end
  end

  task automatic drive_pix(input logic hs, input logic vs, input logic [9:0] r, g, b);
    @(negedge Clock);
    iPixel_En = 1'b1;
    iVGA_H_SYNC = hs; iVGA_V_SYNC = vs;
    iVGA_R = r; iVGA_G = g; iVGA_B = b;
    @(negedge Clock);
    iPixel_En = 1'b0;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive_pix(1'b1, 1'b1, '0, '0, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, int'(oPixel_Valid), 0);
    chk({tag, "_fs"},    int'(oFrame_Start), 0);
    chk({tag, "_lock"},  int'(oLocked), 0);
    chk({tag, "_err"},   int'(oErr), 0);
    chk({tag, "_rgb"},   int'({oVGA_R, oVGA_G, oVGA_B}), 0);
    chk({tag, "_xy"},    int'({oCoord_X, oCoord_Y}), 0);
    chk({tag, "_htot"},  int'(oH_Total), 0);
    chk({tag, "_hsw"},   int'(oH_Sync_W), 0);
    chk({tag, "_vtot"},  int'(oV_Total), 0);
    chk({tag, "_vsw"},   int'(oV_Sync_W), 0);
  endtask

  task automatic run_row(input vec_t v, input int early_next, input string tag);
    int fs0, er0, vd0, pix, len;
    logic hs, vs;
    logic [9:0] bb;
    fs0 = fs_tot; er0 = err_tot; vd0 = vld_tot; pix = 0;
    for (int l = 0; l < v.nlines && pix < v.max_pix; l++) begin
      len = (l == v.short_line) ? H_TOT - 1 : H_TOT;
      for (int c = 0; c < len && pix < v.max_pix; c++) begin
        if (l == 0 && c == 0 && v.early == 0) v_low_left = V_SYNC * H_TOT;
        if (early_next != 0 && l == v.nlines - 1 && c == len - 5) v_low_left = V_SYNC * H_TOT;
        hs = (c >= ((l == v.wide_line) ? H_SYNC + 1 : H_SYNC));
        vs = (v_low_left == 0);
        if (v_low_left > 0) v_low_left--;
        bb = 10'($urandom_range(0, 1023));
        if (v.exp_lk != 0 && c >= X_ST && c < X_ST + H_ACT && l >= Y_ST && l < Y_ST + V_ACT)
          sb.push_back('{x: 10'(c - X_ST), y: 10'(l - Y_ST), r: 10'(c), g: 10'(l), b: bb});
        drive_pix(hs, vs, 10'(c), 10'(l), bb);
        pix++;
      end
    end
    if (v.max_pix == FULL) begin
      chk({tag, "_frame_starts"}, fs_tot - fs0, 1);
      chk({tag, "_err_pulses"},   err_tot - er0, v.exp_err);
      chk({tag, "_valid_count"},  vld_tot - vd0, v.exp_valid);
      chk({tag, "_locked"},       int'(oLocked), v.exp_lk);
      chk({tag, "_h_total"},      int'(oH_Total), H_TOT);
      chk({tag, "_h_sync_w"},     int'(oH_Sync_W), H_SYNC);
      chk({tag, "_v_sync_w"},     int'(oV_Sync_W), V_SYNC);
      if (v.exp_vtot != 0) chk({tag, "_v_total"}, int'(oV_Total), v.exp_vtot);
    end
  endtask

  initial begin
    int er0, vd0, fs0;
    vec_t r;
    tbl[0]  = '{12, -1, -1, FULL, 0, 0, 0,  0,  0};
    tbl[1]  = '{12, -1, -1, FULL, 0, 0, 0, 12,  0};
    tbl[2]  = '{12, -1, -1, FULL, 0, 1, 0, 12, 60};
    tbl[3]  = '{12, -1, -1, FULL, 1, 1, 0, 12, 60};
    tbl[4]  = '{12,  7, -1, FULL, 0, 1, 0, 12, 60};
    tbl[5]  = '{12, -1, -1, FULL, 0, 0, 1, 12,  0};
    tbl[6]  = '{12, -1, -1, FULL, 0, 0, 0, 12,  0};
    tbl[7]  = '{12, -1, -1, FULL, 0, 0, 0, 12,  0};
    tbl[8]  = '{12, -1, -1, FULL, 0, 1, 0, 12, 60};
    tbl[9]  = '{11, -1, -1, FULL, 0, 1, 0, 12, 60};
    tbl[10] = '{12, -1, -1, FULL, 0, 0, 1, 11,  0};
    tbl[11] = '{12, -1,  5, FULL, 0, 0, 0, 12,  0};
    tbl[12] = '{12, -1, -1, FULL, 0, 0, 1, 12,  0};
    tbl[13] = '{12, -1, -1, FULL, 0, 0, 0, 12,  0};
    tbl[14] = '{12, -1, -1, FULL, 0, 1, 0, 12, 60};

    repeat (3) @(negedge Clock);
    check_zero("reset");
    Reset = 1'b0;
    drive_idle(5);

    for (int i = 0; i < 15; i++)
      run_row(tbl[i], (i < 14) ? tbl[i+1].early : 0, $sformatf("row%0d", i));

    // H sync stuck high while locked: saturation, a single error pulse, lock lost
    er0 = err_tot; vd0 = vld_tot; fs0 = fs_tot;
    drive_idle(2100);
    chk("sat_err_pulses", err_tot - er0, 1);
    chk("sat_valid_count", vld_tot - vd0, 0);
    chk("sat_frame_starts", fs_tot - fs0, 0);
    chk("sat_locked", int'(oLocked), 0);

    // Relock from the saturated state, then asynchronous reset mid-frame
    r = '{12, -1, -1, FULL, 0, 0, 0, 0, 0};
    run_row(r, 0, "resync0");
    r.exp_vtot = 12;
    run_row(r, 0, "resync1");
    r.exp_lk = 1; r.exp_valid = 60;
    run_row(r, 0, "resync2");
    r.max_pix = 7 * H_TOT + 8;
    run_row(r, 0, "midframe");
    #2 Reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    v_low_left = 0;
    drive_idle(5);

    r = '{12, -1, -1, FULL, 0, 0, 0, 0, 0};
    run_row(r, 0, "relock0");
    r.exp_vtot = 12;
    run_row(r, 0, "relock1");
    r.exp_lk = 1; r.exp_valid = 60;
    run_row(r, 0, "relock2");

    drive_idle(3);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
